input_sprite_reader: RTL and testbench

- Read-side client of the input-viewer sprite ROMs: `fill_rom` (e.g. `ddownfill_rom`) and `outline_rom`.
- Both ROMs take `row`/`col` and return a 12-bit colour one clock later.
- Per active-video pixel, the block:
  - generates the shared ROM address;
  - realigns hit/valid with the ROM latency;
  - composites fill over outline according to a frame-latched button state.
- Sits between the VGA timing generator and the pixel mixer, one instance per button glyph.

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/sprite_window_calc.sv | 39 +++
 rtl/input_sprite_reader.sv | 142 ++++++++++++++
 tb/tb_input_sprite_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the input-viewer sprite readers.
// The mixer uses SPR_LAT to line up its other layers with sprite pixels.
package sprite_pkg;

    localparam int SPR_W   = 584;   // sprite width in pixels
    localparam int SPR_H   = 167;   // sprite height in rows
    localparam int COLOR_W = 12;    // RGB444
    localparam int ROW_W   = 8;     // ROM row address width
    localparam int COL_W   = 10;    // ROM column address width
    localparam int SPR_LAT = 3;     // pix_x/pix_y -> pixel_out latency in clocks

    typedef logic [COLOR_W-1:0] rgb444_t;

    // ROM colour that is treated as "no paint here".
    localparam rgb444_t COLOR_KEY = 12'h000;

    // True when a ROM colour should be painted rather than treated as transparent.
    function automatic logic color_is_solid(input rgb444_t c);
        return (c != COLOR_KEY);
    endfunction

endpackage

// File: rtl/sprite_window_calc.sv
// Combinational sprite window test: the pixel position relative to the sprite
// origin, checked against the sprite bounds. There is no wrap-around. A pixel
// left of or above the origin gives a negative difference, bit 10 is set, and
// the pixel is a miss.
import sprite_pkg::*;

module sprite_window_calc (
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    input  logic [9:0]       org_x,
    input  logic [9:0]       org_y,
    input  logic             pix_valid,
    output logic             hit,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);

    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic        in_x_s;
    logic        in_y_s;

    // Offset from the sprite origin, bounds check, and ROM row/col (zeroed on a miss).
    always_comb begin
        dx_s   = {1'b0, pix_x} - {1'b0, org_x};
        dy_s   = {1'b0, pix_y} - {1'b0, org_y};
        in_x_s = ~dx_s[10] & (dx_s < 11'(SPR_W));
        in_y_s = ~dy_s[10] & (dy_s < 11'(SPR_H));
        hit    = pix_valid & in_x_s & in_y_s;
        if (hit) begin
            row = dy_s[ROW_W-1:0];
            col = dx_s[COL_W-1:0];
        end else begin
            row = {ROW_W{1'b0}};
            col = {COL_W{1'b0}};
        end
    end

endmodule

// File: rtl/input_sprite_reader.sv
// Read-side client of one button glyph's fill/outline sprite ROMs.
// Stage A registers the shared ROM address and the window hit. The ROMs then
// add one clock. The output stage composites fill over outline, using the
// button state latched at the start of the frame. Latency is 3 clocks, with
// one pixel per clock.
import sprite_pkg::*;

module input_sprite_reader (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [9:0]         sprite_x,
    input  logic [9:0]         sprite_y,
    input  logic               btn_pressed,
    output logic [ROW_W-1:0]   rom_row,
    output logic [COL_W-1:0]   rom_col,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic [COLOR_W-1:0] outline_color,
    output logic               out_valid,
    output logic               out_opaque,
    output logic [COLOR_W-1:0] pixel_out
);

    // Frame shadow registers
    logic [9:0]         sx_q, sx_d;
    logic [9:0]         sy_q, sy_d;
    logic               pressed_q, pressed_d;

    // Stage A
    logic [ROW_W-1:0]   rom_row_q, rom_row_d;
    logic [COL_W-1:0]   rom_col_q, rom_col_d;
    logic               valid_a_q, valid_a_d;
    logic               hit_a_q, hit_a_d;

    // ROM stage alignment
    logic               valid_b_q, valid_b_d;
    logic               hit_b_q, hit_b_d;

    // Output stage
    logic               out_valid_q, out_valid_d;
    logic               out_opaque_q, out_opaque_d;
    logic [COLOR_W-1:0] pixel_out_q, pixel_out_d;

    logic               win_hit_s;
    logic [ROW_W-1:0]   win_row_s;
    logic [COL_W-1:0]   win_col_s;
    logic               fill_on_s;
    logic               line_on_s;

    sprite_window_calc u_window (
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .org_x     (sx_q),
        .org_y     (sy_q),
        .pix_valid (pix_valid),
        .hit       (win_hit_s),
        .row       (win_row_s),
        .col       (win_col_s)
    );

    // Latch sprite position and button state only at frame start, so the glyph never tears mid-frame.
    always_comb begin
        sx_d      = sx_q;
        sy_d      = sy_q;
        pressed_d = pressed_q;
        if (frame_start) begin
            sx_d      = sprite_x;
            sy_d      = sprite_y;
            pressed_d = btn_pressed;
        end else begin
            sx_d      = sx_q;
            sy_d      = sy_q;
            pressed_d = pressed_q;
        end
    end

    // Stage A (ROM address and window hit) and the ROM-latency alignment stage.
    always_comb begin
        rom_row_d = win_row_s;
        rom_col_d = win_col_s;
        valid_a_d = pix_valid;
        hit_a_d   = win_hit_s;
        valid_b_d = valid_a_q;
        hit_b_d   = hit_a_q;
    end

    // Composite fill over outline. Fill is painted only while the latched button is pressed.
    always_comb begin
        fill_on_s    = hit_b_q & pressed_q & color_is_solid(fill_color);
        line_on_s    = hit_b_q & color_is_solid(outline_color);
        out_valid_d  = valid_b_q;
        out_opaque_d = fill_on_s | line_on_s;
        if (fill_on_s) begin
            pixel_out_d = fill_color;
        end else if (line_on_s) begin
            pixel_out_d = outline_color;
        end else begin
            pixel_out_d = {COLOR_W{1'b0}};
        end
    end

    // Pipeline and shadow state. Async reset clears everything, including the shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q         <= 10'd0;
            sy_q         <= 10'd0;
            pressed_q    <= 1'b0;
            rom_row_q    <= {ROW_W{1'b0}};
            rom_col_q    <= {COL_W{1'b0}};
            valid_a_q    <= 1'b0;
            hit_a_q      <= 1'b0;
            valid_b_q    <= 1'b0;
            hit_b_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_opaque_q <= 1'b0;
            pixel_out_q  <= {COLOR_W{1'b0}};
        end else begin
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            pressed_q    <= pressed_d;
            rom_row_q    <= rom_row_d;
            rom_col_q    <= rom_col_d;
            valid_a_q    <= valid_a_d;
            hit_a_q      <= hit_a_d;
            valid_b_q    <= valid_b_d;
            hit_b_q      <= hit_b_d;
            out_valid_q  <= out_valid_d;
            out_opaque_q <= out_opaque_d;
            pixel_out_q  <= pixel_out_d;
        end
    end

    assign rom_row    = rom_row_q;
    assign rom_col    = rom_col_q;
    assign out_valid  = out_valid_q;
    assign out_opaque = out_opaque_q;
    assign pixel_out  = pixel_out_q;

endmodule

// File: tb/tb_input_sprite_reader.sv
// Scoreboard bench for input_sprite_reader. The bench models both ROMs
// behaviourally, with one clock of latency. It drives pixels and frame
// starts, and pushes the expected ROM address (checked 1 clock later) and the
// expected composited output (checked 3 clocks later).
module tb_input_sprite_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = 10'd0;
    logic [9:0]  pix_y = 10'd0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  sprite_x = 10'd0;
    logic [9:0]  sprite_y = 10'd0;
    logic        btn_pressed = 1'b0;
    logic [7:0]  rom_row;
    logic [9:0]  rom_col;
    logic [11:0] fill_color = 12'h000;
    logic [11:0] outline_color = 12'h000;
    logic        out_valid;
    logic        out_opaque;
    logic [11:0] pixel_out;

    input_sprite_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_valid     (pix_valid),
        .frame_start   (frame_start),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .btn_pressed   (btn_pressed),
        .rom_row       (rom_row),
        .rom_col       (rom_col),
        .fill_color    (fill_color),
        .outline_color (outline_color),
        .out_valid     (out_valid),
        .out_opaque    (out_opaque),
        .pixel_out     (pixel_out)
    );

    always #5 clk = ~clk;

    // ROM contents, with an optional override at index (128,325)
    logic        ovr_en = 1'b0;
    logic [11:0] ovr_fill = 12'h000;
    logic [11:0] ovr_line = 12'h000;

    function automatic logic [11:0] fill_fn(input int row, input int col);
        logic [11:0] v;
        if (ovr_en && row == 128 && col == 325) return ovr_fill;
        if (((row ^ col) & 3) == 0) return 12'h000;
        v = 12'((row % 16) * 256 + (col % 256));
        return v;
    endfunction

    function automatic logic [11:0] line_fn(input int row, input int col);
        logic [11:0] v;
        if (ovr_en && row == 128 && col == 325) return ovr_line;
        if ((col % 5) == 0) return 12'h000;
        v = 12'((col % 16) * 256 + (row % 256)) ^ 12'hA5A;
        return v;
    endfunction

    // Behavioural fill and outline ROMs with one clock of read latency.
    always @(posedge clk) begin
        fill_color    <= fill_fn(int'(rom_row), int'(rom_col));
        outline_color <= line_fn(int'(rom_row), int'(rom_col));
    end

    typedef struct {
        logic [7:0]  row;
        logic [9:0]  col;
    } addr_exp_t;

    typedef struct {
        logic        valid;
        logic        opaque;
        logic [11:0] pix;
    } out_exp_t;

    addr_exp_t q_addr[$];
    out_exp_t  q_out[$];

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";

    // Reference copy of the frame shadow registers
    int sx_m = 0;
    int sy_m = 0;
    bit pressed_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s:%s got %0h expected %0h", phase, tag, obs, exp_v);
    endtask

    // One pixel clock: compare what is due, then drive the next pixel and record its expectation
    task automatic step(input int x_in, input int y_in, input bit v, input bit fs);
        int        x, y, dx, dy, r, c;
        bit        hit;
        logic [11:0] fc, lc;
        addr_exp_t a;
        out_exp_t  o;
        @(negedge clk);
        if (q_addr.size() > 0) begin
            a = q_addr.pop_front();
            check("rom_row", 32'(rom_row), 32'(a.row));
            check("rom_col", 32'(rom_col), 32'(a.col));
        end
        if (q_out.size() >= 3) begin
            o = q_out.pop_front();
            check("out_valid",  32'(out_valid),  32'(o.valid));
            check("out_opaque", 32'(out_opaque), 32'(o.opaque));
            check("pixel_out",  32'(pixel_out),  32'(o.pix));
        end
        x = x_in & 1023;
        y = y_in & 1023;
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        pix_valid   = v;
        frame_start = fs;
        dx  = x - sx_m;
        dy  = y - sy_m;
        hit = v && dx >= 0 && dx < 584 && dy >= 0 && dy < 167;
        r   = hit ? dy : 0;
        c   = hit ? dx : 0;
        a.row = 8'(r);
        a.col = 10'(c);
        q_addr.push_back(a);
        fc = fill_fn(r, c);
        lc = line_fn(r, c);
        o.valid = v;
        if (hit && pressed_m && fc != 12'h000) begin
            o.opaque = 1'b1; o.pix = fc;
        end else if (hit && lc != 12'h000) begin
            o.opaque = 1'b1; o.pix = lc;
        end else begin
            o.opaque = 1'b0; o.pix = 12'h000;
        end
        q_out.push_back(o);
        if (fs) begin
            sx_m      = int'(sprite_x);
            sy_m      = int'(sprite_y);
            pressed_m = btn_pressed;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held while stimulus toggles: every output stays zero
        phase = "reset";
        sprite_x = 10'd100; sprite_y = 10'd50; btn_pressed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_x = 10'd100 + 10'(i); pix_y = 10'd50; pix_valid = 1'b1; frame_start = (i == 0);
            @(negedge clk);
            check("rst_valid",  32'(out_valid),  32'd0);
            check("rst_opaque", 32'(out_opaque), 32'd0);
            check("rst_pixel",  32'(pixel_out),  32'd0);
            check("rst_row",    32'(rom_row),    32'd0);
            check("rst_col",    32'(rom_col),    32'd0);
        end
        @(negedge clk);
        pix_valid = 1'b0; frame_start = 1'b0;
        rst_n = 1'b1;

        // Sprite at (100,50) pressed: origin, edges, fill stripe
        phase = "bounds";
        ovr_en = 1'b1; ovr_fill = 12'hFFF; ovr_line = 12'h0F0;
        step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1, 1'b0);
        step(683, 50, 1'b1, 1'b0);
        step(684, 50, 1'b1, 1'b0);
        step(100, 216, 1'b1, 1'b0);
        step(100, 217, 1'b1, 1'b0);
        step(99, 50, 1'b1, 1'b0);
        step(100, 49, 1'b1, 1'b0);
        phase = "fill_fff";
        step(425, 178, 1'b1, 1'b0);
        idle(3);
        phase = "fill_key";
        ovr_fill = 12'h000;
        idle(1);
        step(425, 178, 1'b1, 1'b0);
        idle(3);

        // Button released and sprite moved mid-frame: nothing changes until frame_start
        phase = "latch";
        ovr_fill = 12'hFFF;
        idle(1);
        btn_pressed = 1'b0;
        step(425, 178, 1'b1, 1'b0);
        sprite_x = 10'd200;
        step(425, 178, 1'b1, 1'b0);
        idle(3);
        step(0, 0, 1'b0, 1'b1);
        step(425, 178, 1'b1, 1'b0);
        step(525, 178, 1'b1, 1'b0);
        idle(3);

        // No wrap-around at the right of the screen
        phase = "nowrap";
        sprite_x = 10'd900;
        step(0, 0, 1'b0, 1'b1);
        step(10, 50, 1'b1, 1'b0);
        step(1023, 50, 1'b1, 1'b0);
        // frame_start together with a valid pixel: that pixel still sees the old origin
        phase = "fs_coinc";
        sprite_x = 10'd0;
        step(1000, 60, 1'b1, 1'b1);
        step(1000, 60, 1'b1, 1'b0);
        step(300, 60, 1'b1, 1'b0);
        idle(3);

        // Random frames around a random sprite position
        phase = "random";
        for (int f = 0; f < 4; f++) begin
            sprite_x    = 10'($urandom_range(0, 1023));
            sprite_y    = 10'($urandom_range(0, 700));
            btn_pressed = 1'($urandom_range(0, 1));
            step(0, 0, 1'b0, 1'b1);
            for (int p = 0; p < 40; p++) begin
                step(int'(sprite_x) + int'($urandom_range(0, 700)) - 50,
                     int'(sprite_y) + int'($urandom_range(0, 220)) - 20,
                     ($urandom_range(0, 9) != 0), 1'b0);
            end
            idle(3);
        end

        // Reset mid-stream clears the outputs without a clock edge
        phase = "midrst";
        sprite_x = 10'd100; sprite_y = 10'd50; btn_pressed = 1'b1;
        step(0, 0, 1'b0, 1'b1);
        step(150, 60, 1'b1, 1'b0);
        step(151, 60, 1'b1, 1'b0);
        step(152, 60, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_valid",  32'(out_valid),  32'd0);
        check("async_opaque", 32'(out_opaque), 32'd0);
        check("async_pixel",  32'(pixel_out),  32'd0);
        check("async_row",    32'(rom_row),    32'd0);
        check("async_col",    32'(rom_col),    32'd0);
        q_addr.delete();
        q_out.delete();
        sx_m = 0; sy_m = 0; pressed_m = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        phase = "post_rst";
        step(5, 5, 1'b1, 1'b0);
        step(583, 166, 1'b1, 1'b0);
        step(584, 5, 1'b1, 1'b0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
